shift_reg_univ: RTL

- Parametrised universal shift register, the next generation of the fixed 4-bit serial-in shift register.
- Adds:
  - generic width;
  - left/right shift, rotate and parallel load modes;
  - clock enable and synchronous preset;
  - a shift counter with a one-cycle frame-complete pulse.
- Used as the serial/parallel conversion element in the datapath exercises, and as a building block for LFSR and UART-style labs.

---
 rtl/shift_reg_univ.sv | 98 +++++++++
 1 files changed

// File: rtl/shift_reg_univ.sv
// Universal shift register: left/right shift, rotate, parallel load, clock enable,
// synchronous preset, plus a shift counter that pulses done at the end of each frame.
module shift_reg_univ #(
    parameter int              WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter int              CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             pr,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_SHR  = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_ROR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_LOAD = 3'b101
    } mode_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] q_nxt;
    logic             shift_op;
    logic             load_op;

    always_comb begin
        q_nxt    = q;
        shift_op = 1'b0;
        load_op  = 1'b0;
        case (mode)
            MODE_SHR: begin
                q_nxt    = {sin_r, q[WIDTH-1:1]};
                shift_op = 1'b1;
            end
            MODE_SHL: begin
                q_nxt    = {q[WIDTH-2:0], sin_l};
                shift_op = 1'b1;
            end
            MODE_ROR: begin
                q_nxt    = {q[0], q[WIDTH-1:1]};
                shift_op = 1'b1;
            end
            MODE_ROL: begin
                q_nxt    = {q[WIDTH-2:0], q[WIDTH-1]};
                shift_op = 1'b1;
            end
            MODE_LOAD: begin
                q_nxt   = d;
                load_op = 1'b1;
            end
            default: ; // hold and reserved codes keep q
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q    <= RESET_VAL;
            cnt  <= '0;
            done <= 1'b0;
        end else if (!pr) begin
            q    <= {WIDTH{1'b1}};
            cnt  <= '0;
            done <= 1'b0;
        end else if (!en) begin
            done <= 1'b0;
        end else begin
            q    <= q_nxt;
            done <= 1'b0;
            if (load_op) begin
                cnt <= '0;
            end else if (shift_op) begin
                // wrap on the WIDTH-th shift so back-to-back frames have no gap
                if (cnt == CNT_LAST) begin
                    cnt  <= '0;
                    done <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];

endmodule
